// File: rtl/regfile_pkg.sv
// Shared constants for the write-back register file: bus widths, the zero
// word, the hardwired-zero register address, enable encodings and reset level.
package regfile_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;

  typedef logic [REG_BUS_W-1:0]      reg_bus_t;
  typedef logic [REG_ADDR_BUS_W-1:0] reg_addr_bus_t;

  localparam reg_bus_t      ZERO_WORD    = '0;
  localparam reg_addr_bus_t NOP_REG_ADDR = '0;

  localparam logic RD_ENABLE  = 1'b1;
  localparam logic RD_DISABLE = 1'b0;
  localparam logic WR_ENABLE  = 1'b1;
  localparam logic WR_DISABLE = 1'b0;

  // rst is active-low: this is the level that holds the file in reset.
  localparam logic RST_ACTIVE = 1'b0;

endpackage

// File: rtl/regfile_rport.sv
// One read port: priority mux over reset, read enable, r0, same-cycle
// forwarding of the write-back value, and finally the committed array value.
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int DATA_W    = REG_BUS_W,
  parameter int ADDR_W    = REG_ADDR_BUS_W,
  parameter int BYPASS_EN = 1
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] array_rdata,
  output logic [DATA_W-1:0] rdata
);

  always_comb begin
    rdata = '0;
    if (rst == RST_ACTIVE) begin
      rdata = '0;
    end else if (re == RD_DISABLE) begin
      rdata = '0;
    end else if (raddr == ADDR_W'(NOP_REG_ADDR)) begin
      // r0 never forwards, even when write-back targets it.
      rdata = '0;
    end else if ((BYPASS_EN != 0) && (we == WR_ENABLE) && (waddr == raddr)) begin
      rdata = wdata;
    end else begin
      rdata = array_rdata;
    end
  end

endmodule

// File: rtl/regfile.sv
// Write-back register file: one write port, two independent read ports with
// optional same-cycle forwarding, r0 hardwired to zero, async active-low reset.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W    = REG_BUS_W,
  parameter int ADDR_W    = REG_ADDR_BUS_W,
  parameter int NUM_REGS  = 2 ** ADDR_W,
  parameter int BYPASS_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_commit_d;

  assign wr_commit_d = (we == WR_ENABLE) && (waddr != ADDR_W'(NOP_REG_ADDR));

  // Whole array clears asynchronously so reads are defined the moment rst drops.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit_d) begin
      regs_q[waddr] <= wdata;
    end
  end

  logic              port_re    [2];
  logic [ADDR_W-1:0] port_raddr [2];
  logic [DATA_W-1:0] port_rdata [2];

  assign port_re[0]    = re1;
  assign port_re[1]    = re2;
  assign port_raddr[0] = raddr1;
  assign port_raddr[1] = raddr2;
  assign rdata1        = port_rdata[0];
  assign rdata2        = port_rdata[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      regfile_rport #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
      ) u_rport (
        .rst         (rst),
        .re          (port_re[gi]),
        .raddr       (port_raddr[gi]),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .array_rdata (regs_q[port_raddr[gi]]),
        .rdata       (port_rdata[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench: a forwarding and a non-forwarding register file share
// stimulus and are compared against an array-based model of the read rules.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1;
  logic [4:0]  raddr1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;

  logic [31:0] model [32];
  int total = 0;
  int bad   = 0;

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS_EN(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_b),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_b)
  );

  regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1_n),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value straight from the read-port rules.
  function automatic logic [31:0] exp_read(input bit byp, input logic r, input logic [4:0] a);
    if (rst !== 1'b1) return 32'h0;
    if (r !== 1'b1) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp && we === 1'b1 && waddr == a) return wdata;
    return model[a];
  endfunction

  // Advance one rising edge, commit into the model, land on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst === 1'b1 && we === 1'b1 && waddr != 5'd0) begin
      model[waddr] = wdata;
      $display("wr r%0d <= %h", waddr, wdata);
    end
    @(negedge clk);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    repeat (3) begin
      step();
      #1;
      total++;
      if (rdata1_b !== 32'h0) begin bad++; $display("FAIL reset_hold rdata1 got=%h exp=%h", rdata1_b, 32'h0); end
    end
    we = 1'b0; rst = 1'b1;
    step();
    #1;
    total++;
    if (rdata1_b !== 32'h0) begin bad++; $display("FAIL reset_release_byp rdata1 got=%h exp=%h", rdata1_b, 32'h0); end
    total++;
    if (rdata1_n !== 32'h0) begin bad++; $display("FAIL reset_release_nb rdata1 got=%h exp=%h", rdata1_n, 32'h0); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    write_reg(5'd7, 32'h12345678);
    re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
    #1;
    total++;
    if (rdata1_b !== 32'h12345678) begin bad++; $display("FAIL basic rdata1 got=%h exp=%h", rdata1_b, 32'h12345678); end
    total++;
    if (rdata2_b !== 32'h12345678) begin bad++; $display("FAIL basic rdata2 got=%h exp=%h", rdata2_b, 32'h12345678); end
    total++;
    if (rdata2_n !== 32'h12345678) begin bad++; $display("FAIL basic_nb rdata2 got=%h exp=%h", rdata2_n, 32'h12345678); end
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    total++;
    if (rdata1_b !== 32'h0) begin bad++; $display("FAIL r0_no_forward rdata1 got=%h exp=%h", rdata1_b, 32'h0); end
    step();
    we = 1'b0;
    #1;
    total++;
    if (rdata1_b !== 32'h0) begin bad++; $display("FAIL r0_after_write rdata1 got=%h exp=%h", rdata1_b, 32'h0); end
    total++;
    if (rdata1_n !== 32'h0) begin bad++; $display("FAIL r0_after_write_nb rdata1 got=%h exp=%h", rdata1_n, 32'h0); end
  endtask

  task automatic test_bypass();
    write_reg(5'd3, 32'h1);
    we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
    #1;
    total++;
    if (rdata1_b !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_fwd rdata1 got=%h exp=%h", rdata1_b, 32'hA5A5A5A5); end
    total++;
    if (rdata2_b !== 32'hA5A5A5A5) begin bad++; $display("FAIL bypass_fwd rdata2 got=%h exp=%h", rdata2_b, 32'hA5A5A5A5); end
    total++;
    if (rdata1_n !== 32'h1) begin bad++; $display("FAIL nobypass_old rdata1 got=%h exp=%h", rdata1_n, 32'h1); end
    step();
    we = 1'b0;
    #1;
    total++;
    if (rdata1_n !== 32'hA5A5A5A5) begin bad++; $display("FAIL nobypass_new rdata1 got=%h exp=%h", rdata1_n, 32'hA5A5A5A5); end
  endtask

  task automatic test_re_gating();
    write_reg(5'd9, 32'h55);
    re2 = 1'b0; raddr2 = 5'd9;
    #1;
    total++;
    if (rdata2_b !== 32'h0) begin bad++; $display("FAIL re_gate_off rdata2 got=%h exp=%h", rdata2_b, 32'h0); end
    re2 = 1'b1;
    #1;
    total++;
    if (rdata2_b !== 32'h55) begin bad++; $display("FAIL re_gate_on rdata2 got=%h exp=%h", rdata2_b, 32'h55); end
  endtask

  task automatic test_random();
    logic [31:0] e1b, e2b, e1n, e2n;
    for (int n = 0; n < 300; n++) begin
      we     = ($urandom_range(0, 2) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 4) != 0);
      re2    = ($urandom_range(0, 4) != 0);
      // Bias read addresses toward the write address to exercise forwarding.
      raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      e1b = exp_read(1'b1, re1, raddr1);
      e2b = exp_read(1'b1, re2, raddr2);
      e1n = exp_read(1'b0, re1, raddr1);
      e2n = exp_read(1'b0, re2, raddr2);
      total++;
      if (rdata1_b !== e1b) begin bad++; $display("FAIL rand_byp rdata1 n=%0d a=%0d got=%h exp=%h", n, raddr1, rdata1_b, e1b); end
      total++;
      if (rdata2_b !== e2b) begin bad++; $display("FAIL rand_byp rdata2 n=%0d a=%0d got=%h exp=%h", n, raddr2, rdata2_b, e2b); end
      total++;
      if (rdata1_n !== e1n) begin bad++; $display("FAIL rand_nb rdata1 n=%0d a=%0d got=%h exp=%h", n, raddr1, rdata1_n, e1n); end
      total++;
      if (rdata2_n !== e2n) begin bad++; $display("FAIL rand_nb rdata2 n=%0d a=%0d got=%h exp=%h", n, raddr2, rdata2_n, e2n); end
      step();
    end
    we = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i));
    re1 = 1'b1; raddr1 = 5'd31; re2 = 1'b1; raddr2 = 5'd30;
    #1;
    total++;
    if (rdata1_b !== 32'd31) begin bad++; $display("FAIL pre_reset r31 got=%h exp=%h", rdata1_b, 32'd31); end
    #1;
    rst = 1'b0;
    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFEF00D;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    total++;
    if (rdata1_b !== 32'h0) begin bad++; $display("FAIL async_drop_byp rdata1 got=%h exp=%h", rdata1_b, 32'h0); end
    total++;
    if (rdata1_n !== 32'h0) begin bad++; $display("FAIL async_drop_nb rdata1 got=%h exp=%h", rdata1_n, 32'h0); end
    step();
    we = 1'b0; rst = 1'b1;
    step();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      total++;
      if (rdata1_b !== 32'h0) begin bad++; $display("FAIL post_reset r%0d rdata1 got=%h exp=%h", i, rdata1_b, 32'h0); end
      total++;
      if (rdata2_n !== 32'h0) begin bad++; $display("FAIL post_reset_nb r%0d rdata2 got=%h exp=%h", i, rdata2_n, 32'h0); end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_r0();
    test_bypass();
    test_re_gating();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
